// File: rtl/fp_multiplier_seq.sv
// Sequential IEEE-754 single-precision multiplier with truncating normalisation.
// A shift-add engine forms one partial product per clock under a start/busy/done handshake.
module fp_multiplier_seq #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 23,
    parameter int unsigned BIAS   = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Out,
    output logic        busy,
    output logic        done
);

    localparam int unsigned WORD_W  = 1 + EXP_W + FRAC_W;
    localparam int unsigned MANT_W  = FRAC_W + 1;
    localparam int unsigned PROD_W  = 2 * MANT_W;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned E_W     = EXP_W + 2;
    localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, next_state;

    logic [WORD_W-1:0] a_q, b_q;
    logic [PROD_W-1:0] p_q;
    logic [CNT_W-1:0]  count_q;

    logic              sa, sb, sign_c;
    logic [EXP_W-1:0]  ea, eb;
    logic [FRAC_W-1:0] fa, fb, frac_c;
    logic [MANT_W-1:0] mcand_c, mplier_c;
    logic signed [E_W-1:0] e_c;
    logic [WORD_W-1:0] result_c;

    assign sa = a_q[WORD_W-1];
    assign sb = b_q[WORD_W-1];
    assign ea = a_q[WORD_W-2 -: EXP_W];
    assign eb = b_q[WORD_W-2 -: EXP_W];
    assign fa = a_q[FRAC_W-1:0];
    assign fb = b_q[FRAC_W-1:0];
    assign mcand_c  = {1'b1, fa};
    assign mplier_c = {1'b1, fb};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; start is only honoured in IDLE
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = MUL;
            MUL:  if (count_q == CNT_W'(MANT_W - 1)) next_state = NORM;
            NORM: next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Normalisation and special-case selection from the latched operands
    always_comb begin
        sign_c   = sa ^ sb;
        e_c      = $signed(E_W'(ea)) + $signed(E_W'(eb)) - $signed(E_W'(BIAS))
                 + $signed(E_W'(p_q[PROD_W-1]));
        frac_c   = p_q[PROD_W-1] ? p_q[PROD_W-2 -: FRAC_W] : p_q[PROD_W-3 -: FRAC_W];
        result_c = {sign_c, e_c[EXP_W-1:0], frac_c};
        if ((ea == EXP_W'(EXP_MAX) && fa != '0) || (eb == EXP_W'(EXP_MAX) && fb != '0)) begin
            result_c = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
        end else if ((ea == EXP_W'(EXP_MAX) && eb == '0) || (eb == EXP_W'(EXP_MAX) && ea == '0)) begin
            result_c = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
        end else if (ea == EXP_W'(EXP_MAX) || eb == EXP_W'(EXP_MAX)) begin
            result_c = {sign_c, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (ea == '0 || eb == '0) begin
            result_c = {sign_c, {(WORD_W-1){1'b0}}};
        end else if (e_c >= $signed(E_W'(EXP_MAX))) begin
            result_c = {sign_c, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (e_c <= $signed(E_W'(0))) begin
            result_c = {sign_c, {(WORD_W-1){1'b0}}};
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            count_q <= '0;
            Out     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            busy <= (next_state != IDLE);
            done <= (next_state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        p_q     <= '0;
                        count_q <= '0;
                    end
                end
                MUL: begin
                    if (mplier_c[count_q]) begin
                        p_q <= p_q + (PROD_W'(mcand_c) << count_q);
                    end
                    count_q <= count_q + CNT_W'(1);
                end
                NORM: Out <= result_c;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_multiplier_seq.sv
// Directed bench for fp_multiplier_seq: vector table plus handshake, busy-start and reset-abort sequences.
module tb_fp_multiplier_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Out;
    logic        busy;
    logic        done;

    int n_vec;
    int n_fail;

    fp_multiplier_seq dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .A    (A),
        .B    (B),
        .Out  (Out),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation from start pulse to return to IDLE, checking handshake timing
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name);
        int cycles;
        logic busy_drop;
        A = a;
        B = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({name, " busy@N"}, 32'(busy), 32'd1);
        cycles = 0;
        busy_drop = 1'b0;
        while (!done && cycles < 40) begin
            tick();
            cycles++;
            if (!busy) busy_drop = 1'b1;
        end
        check({name, " latency"}, 32'(cycles), 32'd25);
        check({name, " busy held"}, 32'(busy_drop), 32'd0);
        check({name, " Out"}, Out, exp);
        tick();
        check({name, " done pulse"}, 32'(done), 32'd0);
        check({name, " busy@N+26"}, 32'(busy), 32'd0);
        check({name, " Out held"}, Out, exp);
    endtask

    initial begin
        int n_done;
        n_vec  = 0;
        n_fail = 0;
        vecs[0] = '{32'h3FC00000, 32'h40000000, 32'h40400000, "1.5*2"};
        vecs[1] = '{32'hC0000000, 32'h3F400000, 32'hBFC00000, "-2*0.75"};
        vecs[2] = '{32'h3F800001, 32'h3F800001, 32'h3F800002, "trunc"};
        vecs[3] = '{32'h80000000, 32'h40490FDB, 32'h80000000, "-0*pi"};
        vecs[4] = '{32'h7F800000, 32'h00000000, 32'h7FC00000, "inf*0"};
        vecs[5] = '{32'hFF800000, 32'h40000000, 32'hFF800000, "-inf*2"};
        vecs[6] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, "nan*1"};
        vecs[7] = '{32'h7F000000, 32'h7F000000, 32'h7F800000, "overflow"};
        vecs[8] = '{32'h00800000, 32'h00800000, 32'h00000000, "underflow"};
        vecs[9] = '{32'h0C000000, 32'h33000000, 32'h00000000, "underflow edge"};

        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        tick();
        tick();
        check("reset Out", Out, 32'h0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
        end

        // Second start at N+5 must be ignored
        A = 32'h3FC00000;
        B = 32'h40000000;
        start = 1'b1;
        tick();
        n_done = 0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 5) begin
                start = 1'b1;
                A = 32'h40400000;
                B = 32'h40400000;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) n_done++;
        end
        check("busy start Out", Out, 32'h40400000);
        check("busy start dones", 32'(n_done), 32'd1);
        do_op(32'h40400000, 32'h40400000, 32'h41100000, "3*3 after");

        // Reset asserted at edge N+10 aborts the operation
        A = 32'h3FC00000;
        B = 32'h40000000;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort Out", Out, 32'h0);
        rst = 1'b0;
        n_done = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (done) n_done++;
        end
        check("abort no done", 32'(n_done), 32'd0);
        check("abort Out stays", Out, 32'h0);
        do_op(32'h3FC00000, 32'h40000000, 32'h40400000, "1.5*2 post-abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
